// File: rtl/fact_seq_ctrl.sv
// fact_seq_ctrl: iterative n! sequencer that drives an external 4x32 register
// file (R0 = down-counter, R1 = accumulator, R3 = result copy).
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, n        request and operand (start sampled only in IDLE)
//   busy, done      busy outside IDLE/DONE; done is a one-cycle pulse
//   result          registered low 32 bits of n!
//   overflow        sticky per run, set if any product exceeded 32 bits
//   rf_we/wa/wd     register file write port
//   rf_ra1/ra2      register file read addresses
//   rf_rd1/rd2      combinational register file read data
module fact_seq_ctrl #(
  parameter int N_WIDTH    = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_WIDTH-1:0]    n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  rf_we,
  output logic [1:0]            rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic [1:0]            rf_ra1,
  output logic [1:0]            rf_ra2,
  input  logic [DATA_WIDTH-1:0] rf_rd1,
  input  logic [DATA_WIDTH-1:0] rf_rd2
);

  localparam logic [1:0] R_CNT = 2'd0;
  localparam logic [1:0] R_ACC = 2'd1;
  localparam logic [1:0] R_RES = 2'd3;

  typedef enum logic [2:0] {
    IDLE, INIT_CNT, INIT_ACC, CHECK, MUL, DEC, DONE_WR, DONE
  } state_t;

  state_t               state, state_nxt;
  logic [N_WIDTH-1:0]   n_q;
  logic [2*DATA_WIDTH-1:0] prod;

  // Full-width product so the upper half can flag overflow.
  assign prod = {{DATA_WIDTH{1'b0}}, rf_rd1} * {{DATA_WIDTH{1'b0}}, rf_rd2};

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_q      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        n_q      <= n;
        overflow <= 1'b0;
      end
      if (state == MUL && (prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0))
        overflow <= 1'b1;
      if (state == DONE_WR)
        result <= rf_rd1;
    end
  end

  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    rf_ra1    = '0;
    rf_ra2    = '0;
    case (state)
      IDLE: if (start) state_nxt = INIT_CNT;
      INIT_CNT: begin
        rf_we     = 1'b1;
        rf_wa     = R_CNT;
        rf_wd     = DATA_WIDTH'(n_q);
        state_nxt = INIT_ACC;
      end
      INIT_ACC: begin
        rf_we     = 1'b1;
        rf_wa     = R_ACC;
        rf_wd     = DATA_WIDTH'(1);
        state_nxt = CHECK;
      end
      CHECK: begin
        rf_ra1    = R_CNT;
        state_nxt = (rf_rd1 <= DATA_WIDTH'(1)) ? DONE_WR : MUL;
      end
      MUL: begin
        rf_ra1    = R_ACC;
        rf_ra2    = R_CNT;
        rf_we     = 1'b1;
        rf_wa     = R_ACC;
        rf_wd     = prod[DATA_WIDTH-1:0];
        state_nxt = DEC;
      end
      DEC: begin
        rf_ra1    = R_CNT;
        rf_we     = 1'b1;
        rf_wa     = R_CNT;
        rf_wd     = rf_rd1 - DATA_WIDTH'(1);
        state_nxt = CHECK;
      end
      DONE_WR: begin
        rf_ra1    = R_ACC;
        rf_we     = 1'b1;
        rf_wa     = R_RES;
        rf_wd     = rf_rd1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/fact_seq_ctrl.md
Name: fact_seq_ctrl

Overview:
Sequencing controller that computes n! iteratively, using the 4-entry x 32-bit register file as its working storage. Sits directly upstream of the register file and owns its only write port and both read ports. It consumes the register file's combinational read data for multiply, decrement and compare. Host side is a start/done handshake with a registered result and a sticky overflow flag.

Parameters:
N_WIDTH, 5, width of operand n (0..31)
DATA_WIDTH, 32, register file data width; fixed, must match the register file

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
n  in  N_WIDTH  operand; captured into n_q on the accepted start
busy  out  1  high in every state except IDLE and DONE
done  out  1  one-cycle pulse; high only in DONE
result  out  32  registered n! (low 32 bits); held until the next DONE_WR
overflow  out  1  sticky per run; set if any product exceeded 32 bits
rf_we  out  1  register file write enable
rf_wa  out  2  write address
rf_wd  out  32  write data
rf_ra1  out  2  read address 1
rf_ra2  out  2  read address 2
rf_rd1  in  32  read data 1 (combinational from rf_ra1)
rf_rd2  in  32  read data 2 (combinational from rf_ra2)

Behaviour:
- Register map: R0 = down-counter, R1 = accumulator, R2 = unused, R3 = final result copy.
- rf_* outputs are a combinational decode of state and rf_rd*. In IDLE and DONE: rf_we=0, all addresses=0, rf_wd=0.
- Reset: state=IDLE, busy=0, done=0, result=0, overflow=0, n_q=0. Register file contents are not cleared.
- Reset mid-run: return to IDLE on the next edge. No further writes occur. A partially updated R0/R1 is don't-care.
- IDLE: if start=1, capture n_q=n, clear overflow, and go to INIT_CNT. Otherwise stay in IDLE.
- INIT_CNT: write R0 = zero-extended n_q; go to INIT_ACC.
- INIT_ACC: write R1 = 1; go to CHECK.
- CHECK: rf_ra1=R0, no write. If rf_rd1 <= 1, go to DONE_WR; otherwise go to MUL.
- MUL: rf_ra1=R1, rf_ra2=R0. Form the 64-bit product P = rf_rd1 * rf_rd2 (unsigned). Write R1 = P[31:0]. If P[63:32] != 0, set overflow (sticky). Go to DEC.
- DEC: rf_ra1=R0; write R0 = rf_rd1 - 1; go to CHECK.
- DONE_WR: rf_ra1=R1; write R3 = rf_rd1; load result <= rf_rd1; go to DONE.
- DONE: done=1, busy=0; go to IDLE. A start in DONE is ignored.
- start while busy is ignored, and n changes after capture have no effect.
- Latency: with k = max(n-1, 0), done is high during the cycle after edge 4+3k, counting the start-accepting edge as edge 0. For n=0 or n=1 this is edge 4, with result=1.
- The next start is accepted at the earliest in the IDLE cycle that follows DONE.
- overflow: first set at n=13, since 13! = 6227020800 > 2^32. Once set it stays set until the next accepted start. result then holds the wrapped low 32 bits.

Test Plan:
- rst held 3 cycles, then released with start=0 -> busy=0, done=0, result=0, overflow=0, rf_we=0 for 10 cycles.
- start with n=5 -> done pulses exactly 1 cycle, after edge 16. result=120, overflow=0. R3 reads 120 through a readback port mux in the bench.
- start with n=0, then again with n=1 -> each run gives done after edge 4, result=1, and exactly 3 writes in order R0, R1, R3.
- n=12 -> result=479001600 (0x1C8CFC00), overflow=0. n=13 -> overflow=1, result=0x7328CC00.
- start pulsed during MUL of an n=6 run, with n changed to 3 -> run completes unaffected with result=720.
- rst asserted in the 3rd DEC of an n=7 run -> IDLE and all outputs 0 on the next edge. A new start with n=4 then gives result=24, overflow=0.
